// File: rtl/conv_window_gen_pkg.sv
// Shared definitions for the convolution window generator and its consumers.
// Holds the default geometry, the derived window sizes and the slot-index
// helper that fixes how a KxK window is flattened onto the bus.
package conv_window_gen_pkg;

  localparam int CONV_DATA_WIDTH  = 16;
  localparam int CONV_KERNEL_SIZE = 3;

  localparam int WIN_ELEMS = CONV_KERNEL_SIZE * CONV_KERNEL_SIZE;
  localparam int WIN_BUS_W = WIN_ELEMS * CONV_DATA_WIDTH;

  // Flattened slot of window element (r, c); r=0 is the oldest row, c=0 the leftmost column.
  function automatic int slot_idx(input int r, input int c, input int k);
    return r * k + c;
  endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out bundle between the pixel source, the window generator
// and the convolution engine. The master modport is the pixel source side
// (drives pixels, observes windows); the slave modport is the window generator.
interface conv_window_gen_if
  import conv_window_gen_pkg::*;
#(
  parameter int DATA_WIDTH  = CONV_DATA_WIDTH,
  parameter int KERNEL_SIZE = CONV_KERNEL_SIZE
) ();

  logic [DATA_WIDTH-1:0]                          pixel_in;
  logic                                           pixel_valid;
  logic                                           sof;
  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]  window_out;
  logic                                           window_valid;
  logic                                           frame_done;

  modport master (
    output pixel_in, pixel_valid, sof,
    input  window_out, window_valid, frame_done
  );

  modport slave (
    input  pixel_in, pixel_valid, sof,
    output window_out, window_valid, frame_done
  );

endinterface

// File: rtl/conv_line_buffer.sv
// One image-line delay: a circular buffer addressed by the current column.
// Reading and writing the same address in one cycle returns the pixel stored
// one line earlier, so cascading instances yields successively older lines.
module conv_line_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 28,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign dout = mem[addr];

  // Overwrite this column's entry with the newer line's pixel on every accepted pixel.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[addr] <= din;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Sliding-window generator: turns a raster pixel stream into flattened
// KERNEL_SIZE x KERNEL_SIZE windows (stride 1, no padding), one per fully
// inside position. KERNEL_SIZE-1 cascaded line buffers supply the upper rows
// of each new column; a KxK shift register holds the current window.
// Optional build macro CONV_WIN_OUT_REG_EN adds one more output register stage.
module conv_window_gen
  import conv_window_gen_pkg::*;
#(
  parameter int DATA_WIDTH  = CONV_DATA_WIDTH,
  parameter int KERNEL_SIZE = CONV_KERNEL_SIZE,
  parameter int IMG_WIDTH   = 28,
  parameter int IMG_HEIGHT  = 28
) (
  input  logic             clk,
  input  logic             rst_n,
  conv_window_gen_if.slave bus
);

  localparam int N_ELEMS = KERNEL_SIZE * KERNEL_SIZE;
  localparam int BUS_W   = N_ELEMS * DATA_WIDTH;
  localparam int COL_W   = $clog2(IMG_WIDTH);
  localparam int ROW_W   = $clog2(IMG_HEIGHT);

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(KERNEL_SIZE - 1);
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(KERNEL_SIZE - 1);

  logic                  accept;
  logic [COL_W-1:0]      col_q;
  logic [ROW_W-1:0]      row_q;
  logic [COL_W-1:0]      cur_col;
  logic [ROW_W-1:0]      cur_row;
  logic                  produce;
  logic                  last_pos;

  logic [DATA_WIDTH-1:0] lb_in  [KERNEL_SIZE-1];
  logic [DATA_WIDTH-1:0] lb_out [KERNEL_SIZE-1];
  logic [DATA_WIDTH-1:0] col_data [KERNEL_SIZE];
  logic [DATA_WIDTH-1:0] win_q [KERNEL_SIZE][KERNEL_SIZE];
  logic [DATA_WIDTH-1:0] win_d [KERNEL_SIZE][KERNEL_SIZE];
  logic [BUS_W-1:0]      window_d;

  logic [BUS_W-1:0]      win_out_q;
  logic                  win_valid_q;
  logic                  frame_done_q;

  assign accept = bus.pixel_valid;

  // Position of the pixel on the bus: sof forces it to (0,0) whatever the counters say.
  always_comb begin
    cur_col = col_q;
    cur_row = row_q;
    if (bus.sof) begin
      cur_col = '0;
      cur_row = '0;
    end
  end

  assign produce  = accept && (cur_row >= ROW_FIRST) && (cur_col >= COL_FIRST);
  assign last_pos = (cur_row == ROW_LAST) && (cur_col == COL_LAST);

  // Raster position counters, advanced only on accepted pixels and wrapping at frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (cur_col == COL_LAST) begin
        col_q <= '0;
        row_q <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
      end else begin
        col_q <= cur_col + 1'b1;
        row_q <= cur_row;
      end
    end
  end

  for (genvar j = 0; j < KERNEL_SIZE - 1; j++) begin : g_lb
    if (j == 0) begin : g_head
      assign lb_in[j] = bus.pixel_in;
    end else begin : g_tail
      assign lb_in[j] = lb_out[j-1];
    end

    conv_line_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (IMG_WIDTH),
      .ADDR_W     (COL_W)
    ) u_line (
      .clk  (clk),
      .en   (accept),
      .addr (cur_col),
      .din  (lb_in[j]),
      .dout (lb_out[j])
    );
  end

  // New window column: oldest line at the top, the incoming pixel at the bottom.
  always_comb begin
    col_data[KERNEL_SIZE-1] = bus.pixel_in;
    for (int j = 0; j < KERNEL_SIZE - 1; j++) begin
      col_data[KERNEL_SIZE-2-j] = lb_out[j];
    end
  end

  // Next window: every row shifts left one column and takes the new column on the right.
  always_comb begin
    for (int r = 0; r < KERNEL_SIZE; r++) begin
      for (int c = 0; c < KERNEL_SIZE - 1; c++) begin
        win_d[r][c] = win_q[r][c+1];
      end
      win_d[r][KERNEL_SIZE-1] = col_data[r];
    end
  end

  // Flatten the next window onto the output bus using the shared slot ordering.
  always_comb begin
    window_d = '0;
    for (int r = 0; r < KERNEL_SIZE; r++) begin
      for (int c = 0; c < KERNEL_SIZE; c++) begin
        window_d[slot_idx(r, c, KERNEL_SIZE)*DATA_WIDTH +: DATA_WIDTH] = win_d[r][c];
      end
    end
  end

  // Window shift register, updated only when a pixel is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < KERNEL_SIZE; r++) begin
        for (int c = 0; c < KERNEL_SIZE; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else if (accept) begin
      win_q <= win_d;
    end
  end

  // Output register: capture a window on the producing edge; the pulses last one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_out_q    <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      win_valid_q  <= produce;
      frame_done_q <= produce && last_pos;
      if (produce) begin
        win_out_q <= window_d;
      end
    end
  end

`ifdef CONV_WIN_OUT_REG_EN
  logic [BUS_W-1:0] win_out_q2;
  logic             win_valid_q2;
  logic             frame_done_q2;

  // Extra retiming stage: a plain one-cycle delay of the whole output set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_out_q2    <= '0;
      win_valid_q2  <= 1'b0;
      frame_done_q2 <= 1'b0;
    end else begin
      win_out_q2    <= win_out_q;
      win_valid_q2  <= win_valid_q;
      frame_done_q2 <= frame_done_q;
    end
  end

  assign bus.window_out   = win_out_q2;
  assign bus.window_valid = win_valid_q2;
  assign bus.frame_done   = frame_done_q2;
`else
  assign bus.window_out   = win_out_q;
  assign bus.window_valid = win_valid_q;
  assign bus.frame_done   = frame_done_q;
`endif

endmodule
